// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the shared-adder arbiter block.
// Holds the FSM state type, the default-configuration widths and width helpers
// so that parameterised instances compute their own bus widths.
package adder_arb_pkg;

    localparam int unsigned DEF_W = 8;
    localparam int unsigned DEF_N = 4;

    localparam int unsigned OPW   = 4 * DEF_W + 1;
    localparam int unsigned SUMW  = DEF_W + 2;
    localparam int unsigned IDW   = $clog2(DEF_N);
    localparam int unsigned STATW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Operand bundle width: four W-bit operands plus carry-in.
    function automatic int unsigned opw(input int unsigned w);
        return 4 * w + 1;
    endfunction

    // Sum width large enough for 4*(2^W-1)+1.
    function automatic int unsigned sumw(input int unsigned w);
        return w + 2;
    endfunction

    // Requester index width.
    function automatic int unsigned idw(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/adder_arb_ctrl_if.sv
// Request/response bus of the shared-adder arbiter.
//   req_valid/req_data/req_ready : N requesters, one OPW-bit bundle each
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_zero : single response channel
//   stat_grants : N x 16-bit grant counters (zero when stats are not built)
// slave  = arbiter side, master = client side.
interface adder_arb_ctrl_if
    import adder_arb_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned N = DEF_N
);
    localparam int unsigned BW = opw(W);
    localparam int unsigned SW = sumw(W);
    localparam int unsigned IW = idw(N);

    logic [N-1:0]       req_valid;
    logic [N*BW-1:0]    req_data;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [SW-1:0]      rsp_sum;
    logic               rsp_zero;
    logic [N*STATW-1:0] stat_grants;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_zero, stat_grants
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_zero, stat_grants
    );

endinterface

// File: rtl/adder_arb_ctrl_adder4.sv
// Registered 4-operand adder with carry-in.
//   ins_i  : {cin, w, z, y, x}, x in the low W bits
//   sum_o  : registered x+y+z+w+cin, full width
//   zero_o : registered (sum == 0)
// rst_n is synchronous, active-low.
module adder4 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4*W:0] ins_i,
    output logic [W+1:0] sum_o,
    output logic         zero_o
);

    localparam int unsigned SW = W + 2;

    logic [SW-1:0] sum_c;

    // Zero-extend every term so no carry is lost.
    always_comb begin
        sum_c = SW'(ins_i[W-1:0])     + SW'(ins_i[2*W-1:W])
              + SW'(ins_i[3*W-1:2*W]) + SW'(ins_i[4*W-1:3*W])
              + SW'(ins_i[4*W]);
    end

    // Result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_o  <= '0;
            zero_o <= 1'b0;
        end else begin
            sum_o  <= sum_c;
            zero_o <= (sum_c == '0);
        end
    end

endmodule

// File: rtl/adder_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority index; search wraps N-1 -> 0
//   gnt_o : one-hot grant, idx_o : granted index, any_o : some request present
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // First requester found scanning upward from the pointer.
    always_comb begin
        int unsigned k;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            k = (32'(ptr_i) + off) % N;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/adder_arb_ctrl.sv
// Shares one registered 4-operand adder between N requesters.
// A round-robin winner's bundle is latched, summed in the next cycle and
// presented on the response port until accepted; one operation in flight.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : adder_arb_ctrl_if.slave (request, response, grant statistics)
// Optional build macro ADDER_ARB_STATS_EN: per-requester saturating 16-bit
// grant counters on stat_grants; without it stat_grants is tied to zero.
module adder_arb_ctrl
    import adder_arb_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned N = DEF_N
) (
    input  logic            clk,
    input  logic            rst,
    adder_arb_ctrl_if.slave bus
);

    localparam int unsigned BW = opw(W);
    localparam int unsigned IW = idw(N);

    state_e          state_q, state_d;
    logic [BW-1:0]   op_q, op_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]    arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [N-1:0]    req_ready_c;
    logic            take_c;
    logic [BW-1:0]   slice_c [N];

    // Per-requester view of the flat request bus.
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign slice_c[g] = bus.req_data[g*BW +: BW];
    end

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Next-state logic; a grant is only issued when the result slot is free
    // and never while reset is asserted, so no grant is silently dropped.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        req_ready_c = '0;
        take_c      = 1'b0;

        case (state_q)
            IDLE: take_c = arb_any;
            CALC: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    take_c  = arb_any;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_c && !rst) begin
            req_ready_c = arb_gnt;
            op_d        = slice_c[arb_idx];
            id_d        = arb_idx;
            ptr_d       = (arb_idx == IW'(N - 1)) ? '0 : arb_idx + IW'(1);
            state_d     = CALC;
        end
    end

    // State, operand, id and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    // Operands stay in op_q through RESP, so the registered sum is stable.
    adder4 #(
        .W (W)
    ) u_add (
        .clk    (clk),
        .rst_n  (~rst),
        .ins_i  (op_q),
        .sum_o  (bus.rsp_sum),
        .zero_o (bus.rsp_zero)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;

`ifdef ADDER_ARB_STATS_EN
    logic [STATW-1:0] stat_q [N];

    // Saturating grant counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                stat_q[i] <= '0;
            end else if (req_ready_c[i] && (stat_q[i] != '1)) begin
                stat_q[i] <= stat_q[i] + STATW'(1);
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stat
        assign bus.stat_grants[g*STATW +: STATW] = stat_q[g];
    end
`else
    assign bus.stat_grants = '0;
`endif

endmodule

// File: tb/tb_adder_arb_ctrl.sv
// Directed self-checking bench for adder_arb_ctrl (W=8, N=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_adder_arb_ctrl;
    import adder_arb_pkg::*;

    localparam int unsigned W = DEF_W;
    localparam int unsigned N = DEF_N;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   seq [5] = '{0, 1, 2, 3, 0};
    logic [63:0] st2_exp;
    logic [63:0] st6_exp;

    always #5 clk = ~clk;

    adder_arb_ctrl_if #(.W(W), .N(N)) bus_if ();

    adder_arb_ctrl #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OPW-1:0] bundle(input logic [7:0] x, input logic [7:0] y,
                                             input logic [7:0] z, input logic [7:0] w,
                                             input logic cin);
        return {cin, w, z, y, x};
    endfunction

    task automatic put(input int i, input logic [OPW-1:0] b);
        bus_if.req_data[i*OPW +: OPW] = b;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
`ifdef ADDER_ARB_STATS_EN
        st2_exp = {16'd1, 16'd1, 16'd1, 16'd2};
        st6_exp = {16'd1, 16'd1, 16'd0, 16'd0};
`else
        st2_exp = 64'd0;
        st6_exp = 64'd0;
`endif
        rst              = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.rsp_ready = 1'b1;

        // Reset values
        next_cyc();
        next_cyc();
        mid();
        chk("rst_ready", bus_if.req_ready, 64'd0);
        chk("rst_valid", bus_if.rsp_valid, 64'd0);
        chk("rst_id",    bus_if.rsp_id,    64'd0);
        chk("rst_sum",   bus_if.rsp_sum,   64'd0);
        chk("rst_zero",  bus_if.rsp_zero,  64'd0);
        chk("rst_stat",  bus_if.stat_grants, 64'd0);
        next_cyc();
        rst = 1'b0;
        mid();
        chk("rel_valid", bus_if.rsp_valid, 64'd0);

        // 1: single request, latency 2
        put(0, bundle(8'd1, 8'd2, 8'd3, 8'd4, 1'b1));
        next_cyc();
        bus_if.req_valid = 4'b0001;
        mid();
        chk("t1_ready", bus_if.req_ready, 64'h1);
        next_cyc();
        bus_if.req_valid = 4'b0000;
        mid();
        chk("t1_calc_valid", bus_if.rsp_valid, 64'd0);
        chk("t1_calc_ready", bus_if.req_ready, 64'd0);
        next_cyc();
        mid();
        chk("t1_valid", bus_if.rsp_valid, 64'd1);
        chk("t1_id",    bus_if.rsp_id,    64'(IDW'(0)));
        chk("t1_sum",   bus_if.rsp_sum,   64'(SUMW'(11)));
        chk("t1_zero",  bus_if.rsp_zero,  64'd0);

        // 2: all requesting, fresh pointer -> grants 0,1,2,3,0
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) put(i, bundle(8'(i + 1), 8'd0, 8'd0, 8'd0, 1'b0));
        for (int c = 0; c <= 8; c++) begin
            next_cyc();
            if (c == 0) bus_if.req_valid = 4'b1111;
            mid();
            chk("t2_ready", bus_if.req_ready, (c % 2 == 0) ? (64'd1 << seq[c/2]) : 64'd0);
            if ((c % 2 == 0) && (c >= 2)) begin
                chk("t2_valid", bus_if.rsp_valid, 64'd1);
                chk("t2_id",    bus_if.rsp_id,    64'(seq[c/2-1]));
                chk("t2_sum",   bus_if.rsp_sum,   64'(seq[c/2-1] + 1));
            end else begin
                chk("t2_idle_valid", bus_if.rsp_valid, 64'd0);
            end
        end
        next_cyc();
        bus_if.req_valid = 4'b0000;
        mid();
        chk("t2_stat", bus_if.stat_grants, st2_exp);
        next_cyc();
        mid();
        chk("t2_last_id",  bus_if.rsp_id,  64'd0);
        chk("t2_last_sum", bus_if.rsp_sum, 64'd1);

        // 3: maximum sum, pointer now at 1
        put(1, bundle(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1));
        next_cyc();
        next_cyc();
        bus_if.req_valid = 4'b0010;
        mid();
        chk("t3_ready", bus_if.req_ready, 64'h2);
        next_cyc();
        bus_if.req_valid = 4'b0000;
        next_cyc();
        mid();
        chk("t3_valid", bus_if.rsp_valid, 64'd1);
        chk("t3_id",    bus_if.rsp_id,    64'd1);
        chk("t3_sum",   bus_if.rsp_sum,   64'h3FD);
        chk("t3_zero",  bus_if.rsp_zero,  64'd0);

        // 4: zero sum
        put(2, bundle(8'd0, 8'd0, 8'd0, 8'd0, 1'b0));
        next_cyc();
        next_cyc();
        bus_if.req_valid = 4'b0100;
        mid();
        chk("t4_ready", bus_if.req_ready, 64'h4);
        next_cyc();
        bus_if.req_valid = 4'b0000;
        next_cyc();
        mid();
        chk("t4_id",   bus_if.rsp_id,   64'd2);
        chk("t4_sum",  bus_if.rsp_sum,  64'd0);
        chk("t4_zero", bus_if.rsp_zero, 64'd1);

        // 5: response stalled 5 cycles with req1 pending
        put(3, bundle(8'd10, 8'd20, 8'd30, 8'd40, 1'b0));
        next_cyc();
        next_cyc();
        bus_if.req_valid = 4'b1000;
        mid();
        chk("t5_ready", bus_if.req_ready, 64'h8);
        next_cyc();
        bus_if.req_valid = 4'b0010;
        put(1, bundle(8'd5, 8'd5, 8'd5, 8'd5, 1'b1));
        bus_if.rsp_ready = 1'b0;
        mid();
        chk("t5_calc_ready", bus_if.req_ready, 64'd0);
        for (int s = 0; s < 5; s++) begin
            next_cyc();
            mid();
            chk("t5_stall_valid", bus_if.rsp_valid, 64'd1);
            chk("t5_stall_id",    bus_if.rsp_id,    64'd3);
            chk("t5_stall_sum",   bus_if.rsp_sum,   64'd100);
            chk("t5_stall_ready", bus_if.req_ready, 64'd0);
        end
        next_cyc();
        bus_if.rsp_ready = 1'b1;
        mid();
        chk("t5_rel_ready", bus_if.req_ready, 64'h2);
        chk("t5_rel_valid", bus_if.rsp_valid, 64'd1);
        chk("t5_rel_sum",   bus_if.rsp_sum,   64'd100);
        next_cyc();
        bus_if.req_valid = 4'b0000;
        mid();
        chk("t5_b2b_calc", bus_if.rsp_valid, 64'd0);
        next_cyc();
        mid();
        chk("t5_b2b_valid", bus_if.rsp_valid, 64'd1);
        chk("t5_b2b_id",    bus_if.rsp_id,    64'd1);
        chk("t5_b2b_sum",   bus_if.rsp_sum,   64'd21);

        // 6: reset during CALC drops the op and rewinds the pointer
        put(0, bundle(8'd1, 8'd1, 8'd1, 8'd1, 1'b0));
        next_cyc();
        next_cyc();
        bus_if.req_valid = 4'b0001;
        mid();
        chk("t6_ready", bus_if.req_ready, 64'h1);
        next_cyc();
        bus_if.req_valid = 4'b1100;
        put(2, bundle(8'd2, 8'd2, 8'd2, 8'd2, 1'b1));
        put(3, bundle(8'd3, 8'd3, 8'd3, 8'd3, 1'b0));
        rst = 1'b1;
        mid();
        chk("t6_rst_ready", bus_if.req_ready, 64'd0);
        next_cyc();
        rst = 1'b0;
        mid();
        chk("t6_drop_valid", bus_if.rsp_valid, 64'd0);
        chk("t6_ptr_ready",  bus_if.req_ready, 64'h4);
        next_cyc();
        bus_if.req_valid = 4'b1000;
        mid();
        chk("t6_calc_valid", bus_if.rsp_valid, 64'd0);
        next_cyc();
        mid();
        chk("t6_valid", bus_if.rsp_valid, 64'd1);
        chk("t6_id",    bus_if.rsp_id,    64'd2);
        chk("t6_sum",   bus_if.rsp_sum,   64'd9);
        chk("t6_b2b_ready", bus_if.req_ready, 64'h8);
        next_cyc();
        bus_if.req_valid = 4'b0000;
        mid();
        chk("t6_calc2_valid", bus_if.rsp_valid, 64'd0);
        next_cyc();
        mid();
        chk("t6_id2",  bus_if.rsp_id,      64'd3);
        chk("t6_sum2", bus_if.rsp_sum,     64'd12);
        chk("t6_stat", bus_if.stat_grants, st6_exp);

        next_cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
